// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the sequential binary-to-BCD
//             converter: FSM state encoding, BCD digit width and the
//             double-dabble add-3 threshold.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Conversion FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of one packed 8421 BCD digit
    localparam int C_DIGIT_W = 4;

    // Digits at or above this value get +3 before each shift
    localparam logic [C_DIGIT_W-1:0] C_ADD3_THRESH = 4'd5;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
// ============================================================================
//  Module   : bin2bcd_seq_if
//  Purpose  : Operand/result handshake bundle for bin2bcd_seq. The master
//             side offers operands and consumes results; the slave side is
//             the converter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin2bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [IN_W-1:0]             in_bin;
    logic                        out_valid;
    logic                        out_ready;
    logic [C_DIGIT_W*DIGITS-1:0] out_bcd;
    logic                        out_ovf;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );
endinterface : bin2bcd_seq_if

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
//  Module   : bcd_digit_adj
//  Purpose  : Double-dabble digit correction: adds 3 to a BCD digit that is
//             5 or more so the following left shift carries correctly.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  wire logic [C_DIGIT_W-1:0] i_digit,
    output logic      [C_DIGIT_W-1:0] o_digit
);

    // Conditional add-3 correction
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= C_ADD3_THRESH) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule : bcd_digit_adj

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential shift-and-add-3 binary to packed BCD converter with
//             valid/ready handshakes on operand and result. One operand bit
//             is consumed per cycle; results are held until accepted.
//  Options  : BIN2BCD_BLANK_EN - replace leading-zero digits above digit 0
//             with 4'hF in the presented result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
)(
    input  wire logic     clk,
    input  wire logic     rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int                 C_BCD_W = C_DIGIT_W * DIGITS;
    localparam int                 C_CNT_W = $clog2(IN_W + 1);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(IN_W - 1);

    state_t               state_q,   state_d;
    logic [IN_W-1:0]      shreg_q,   shreg_d;
    logic [C_BCD_W-1:0]   acc_q,     acc_d;
    logic [C_BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic                 ovf_q,     ovf_d;
    logic [C_CNT_W-1:0]   cnt_q,     cnt_d;

    logic [C_BCD_W-1:0]   w_adj;
    logic [C_BCD_W-1:0]   w_acc_shift;
    logic                 w_carry;
    logic [C_BCD_W-1:0]   w_result;

    // One add-3 corrector per accumulator digit
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (acc_q[g*C_DIGIT_W +: C_DIGIT_W]),
                .o_digit (w_adj[g*C_DIGIT_W +: C_DIGIT_W])
            );
        end
    endgenerate

    // Left shift of {adjusted acc, shreg}; the bit leaving the top digit
    // marks that the operand does not fit in DIGITS digits.
    assign w_acc_shift = {w_adj[C_BCD_W-2:0], shreg_q[IN_W-1]};
    assign w_carry     = w_adj[C_BCD_W-1];

`ifdef BIN2BCD_BLANK_EN
    logic w_lead;

    // Blank leading zero digits of the final value; digit 0 always shows
    always_comb begin
        w_result = w_acc_shift;
        w_lead   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (w_acc_shift[i*C_DIGIT_W +: C_DIGIT_W] == '0)) begin
                w_result[i*C_DIGIT_W +: C_DIGIT_W] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    // Plain BCD with leading zeros
    always_comb begin
        w_result = w_acc_shift;
    end
`endif

    // Next-state and datapath control for IDLE -> SHIFT -> DONE
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        out_bcd_d = out_bcd_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shreg_d   = bus.in_bin;
                    acc_d     = '0;
                    out_bcd_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[IN_W-2:0], 1'b0};
                acc_d   = w_acc_shift;
                ovf_d   = ovf_q | w_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    out_bcd_d = w_result;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            out_bcd_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            out_bcd_q <= out_bcd_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_ovf   = ovf_q;

endmodule : bin2bcd_seq

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Purpose  : Self-checking bench for bin2bcd_seq: a 5-digit and a 3-digit
//             instance driven with directed vectors and handshake sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.IN_W(16), .DIGITS(5)) bus5 ();
    bin2bcd_seq_if #(.IN_W(16), .DIGITS(3)) bus3 ();

    bin2bcd_seq #(.IN_W(16), .DIGITS(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));
    bin2bcd_seq #(.IN_W(16), .DIGITS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic [15:0] bin;
        logic [19:0] plain;
        logic [19:0] blank;
        logic        ovf;
    } vec5_t;

    typedef struct {
        logic [15:0] bin;
        logic [11:0] plain;
        logic [11:0] blank;
        logic        ovf;
    } vec3_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Accept one operand on the 5-digit instance, wait for the result,
    // report it and the accept-to-valid latency, then complete the handshake.
    task automatic convert5(input logic [15:0] bin, output logic [19:0] bcd,
                            output logic ovf, output int lat, output bit tmo);
        @(negedge clk);
        bus5.in_valid = 1'b1;
        bus5.in_bin   = bin;
        @(negedge clk);
        bus5.in_valid = 1'b0;
        bus5.in_bin   = ~bin;
        lat = 1;
        while (!bus5.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tmo = !bus5.out_valid;
        bcd = bus5.out_bcd;
        ovf = bus5.out_ovf;
        bus5.out_ready = 1'b1;
        @(negedge clk);
        bus5.out_ready = 1'b0;
    endtask

    task automatic convert3(input logic [15:0] bin, output logic [11:0] bcd,
                            output logic ovf, output bit tmo);
        int lat;
        @(negedge clk);
        bus3.in_valid = 1'b1;
        bus3.in_bin   = bin;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        bus3.in_bin   = ~bin;
        lat = 1;
        while (!bus3.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tmo = !bus3.out_valid;
        bcd = bus3.out_bcd;
        ovf = bus3.out_ovf;
        bus3.out_ready = 1'b1;
        @(negedge clk);
        bus3.out_ready = 1'b0;
    endtask

    initial begin
        vec5_t       v5 [12];
        vec3_t       v3 [3];
        logic [19:0] bcd5;
        logic [11:0] bcd3;
        logic        ovf;
        int          lat;
        bit          tmo;
        bit          seen;
        logic [19:0] exp5;
        logic [11:0] exp3;

        v5[0]  = '{16'd0,     20'h00000, 20'hFFFF0, 1'b0};
        v5[1]  = '{16'd65535, 20'h65535, 20'h65535, 1'b0};
        v5[2]  = '{16'd12345, 20'h12345, 20'h12345, 1'b0};
        v5[3]  = '{16'd42,    20'h00042, 20'hFFF42, 1'b0};
        v5[4]  = '{16'd9,     20'h00009, 20'hFFFF9, 1'b0};
        v5[5]  = '{16'd10,    20'h00010, 20'hFFF10, 1'b0};
        v5[6]  = '{16'd1000,  20'h01000, 20'hF1000, 1'b0};
        v5[7]  = '{16'd40000, 20'h40000, 20'h40000, 1'b0};
        v5[8]  = '{16'd50505, 20'h50505, 20'h50505, 1'b0};
        v5[9]  = '{16'd100,   20'h00100, 20'hFF100, 1'b0};
        v5[10] = '{16'd9999,  20'h09999, 20'hF9999, 1'b0};
        v5[11] = '{16'd1,     20'h00001, 20'hFFFF1, 1'b0};

        v3[0]  = '{16'd1234,  12'h234,   12'h234,   1'b1};
        v3[1]  = '{16'd999,   12'h999,   12'h999,   1'b0};
        v3[2]  = '{16'd1000,  12'h000,   12'hFF0,   1'b1};

        bus5.in_valid = 1'b0; bus5.in_bin = '0; bus5.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_bin = '0; bus3.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready5",  32'(bus5.in_ready),  32'd1);
        check("rst_out_valid5", 32'(bus5.out_valid), 32'd0);
        check("rst_out_bcd5",   32'(bus5.out_bcd),   32'd0);
        check("rst_out_ovf5",   32'(bus5.out_ovf),   32'd0);
        check("rst_in_ready3",  32'(bus3.in_ready),  32'd1);
        check("rst_out_valid3", 32'(bus3.out_valid), 32'd0);

        // 5-digit table
        for (int i = 0; i < 12; i++) begin
`ifdef BIN2BCD_BLANK_EN
            exp5 = v5[i].blank;
`else
            exp5 = v5[i].plain;
`endif
            convert5(v5[i].bin, bcd5, ovf, lat, tmo);
            check($sformatf("v5_timeout[%0d]", i), 32'(tmo),  32'd0);
            check($sformatf("v5_bcd[%0d]", i),     32'(bcd5), 32'(exp5));
            check($sformatf("v5_ovf[%0d]", i),     32'(ovf),  32'(v5[i].ovf));
            check($sformatf("v5_latency[%0d]", i), 32'(lat),  32'd17);
            check($sformatf("v5_ready_after[%0d]", i), 32'(bus5.in_ready), 32'd1);
        end

        // 3-digit table, including truncation
        for (int i = 0; i < 3; i++) begin
`ifdef BIN2BCD_BLANK_EN
            exp3 = v3[i].blank;
`else
            exp3 = v3[i].plain;
`endif
            convert3(v3[i].bin, bcd3, ovf, tmo);
            check($sformatf("v3_timeout[%0d]", i), 32'(tmo),  32'd0);
            check($sformatf("v3_bcd[%0d]", i),     32'(bcd3), 32'(exp3));
            check($sformatf("v3_ovf[%0d]", i),     32'(ovf),  32'(v3[i].ovf));
        end

        // Backpressure: hold result in DONE with out_ready low
        @(negedge clk);
        bus5.in_valid = 1'b1;
        bus5.in_bin   = 16'd12345;
        @(negedge clk);
        bus5.in_valid = 1'b0;
        lat = 1;
        while (!bus5.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_reach_done", 32'(bus5.out_valid), 32'd1);
        bus5.in_valid = 1'b1;
        bus5.in_bin   = 16'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid[%0d]", c), 32'(bus5.out_valid), 32'd1);
            check($sformatf("bp_bcd[%0d]", c),   32'(bus5.out_bcd),   32'h12345);
            check($sformatf("bp_ready[%0d]", c), 32'(bus5.in_ready),  32'd0);
        end
        // Handshake with in_valid still high: no accept in the same cycle
        bus5.out_ready = 1'b1;
        @(negedge clk);
        bus5.out_ready = 1'b0;
        check("bp_idle_after_hs", 32'(bus5.in_ready),  32'd1);
        check("bp_valid_dropped", 32'(bus5.out_valid), 32'd0);
        bus5.in_valid = 1'b0;
        convert5(16'd7, bcd5, ovf, lat, tmo);
`ifdef BIN2BCD_BLANK_EN
        check("bp_resume_bcd", 32'(bcd5), 32'hFFFF7);
`else
        check("bp_resume_bcd", 32'(bcd5), 32'h00007);
`endif
        check("bp_resume_timeout", 32'(tmo), 32'd0);

        // Reset during SHIFT cycle 8 discards the conversion
        @(negedge clk);
        bus5.in_valid = 1'b1;
        bus5.in_bin   = 16'd999;
        @(negedge clk);
        bus5.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("rs_in_shift", 32'(bus5.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_idle_ready", 32'(bus5.in_ready),  32'd1);
        check("rs_no_valid",   32'(bus5.out_valid), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen = seen | bus5.out_valid;
        end
        check("rs_no_valid_pulse", 32'(seen), 32'd0);
        convert5(16'd42, bcd5, ovf, lat, tmo);
`ifdef BIN2BCD_BLANK_EN
        check("rs_next_bcd", 32'(bcd5), 32'hFFF42);
`else
        check("rs_next_bcd", 32'(bcd5), 32'h00042);
`endif
        check("rs_next_ovf", 32'(ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bin2bcd_seq

`default_nettype wire
